// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and helpers for the systolic tile sequencer
//
// Purpose: array geometry (N, KMAX), controller state codes and phase lengths.
// Ports:   none (package).

package systolic_pkg;

  localparam int N    = 4;   // array edge: lanes and columns per side
  localparam int KMAX = 16;  // largest legal inner dimension

  // Wavefront drain length through the aggregator.
  localparam int COLLECT_LEN = 2*N - 1;

  // State codes kept as plain constants so the state register stays a
  // bare vector; the enum below names the same codes for debug views.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    CLEAR   = S_CLEAR,
    FEED    = S_FEED,
    COLLECT = S_COLLECT,
    DONE    = S_DONE
  } ctrl_state_t;

  // Feed window length: K operands plus the 2N-2 cycles of skew across
  // the array. Maximum is 22 for KMAX=16, so 5 bits suffice.
  function automatic logic [4:0] feed_len(input logic [4:0] k);
    return k + 5'(2*N - 2);
  endfunction

endpackage

// File: rtl/systolic_if.sv
// rtl/systolic_if.sv - job handshake and array-control bundle of the systolic sequencer
//
// Purpose: groups the job issuer handshake and the sequencer outputs.
// Ports (signals):
//   start, k_len, res_ready           : issuer -> sequencer
//   busy, err, pe_clear, rd_en,
//   rd_addr, a_vld, b_vld, agg_en,
//   agg_count, res_valid              : sequencer -> issuer / array
// Modports: master = issuer side, slave = sequencer side.

interface systolic_if;
  import systolic_pkg::*;

  logic         start;
  logic [4:0]   k_len;
  logic         res_ready;
  logic         busy;
  logic         err;
  logic         pe_clear;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic [N-1:0] a_vld;
  logic [N-1:0] b_vld;
  logic         agg_en;
  logic [4:0]   agg_count;
  logic         res_valid;

  modport master (
    output start, k_len, res_ready,
    input  busy, err, pe_clear, rd_en, rd_addr, a_vld, b_vld,
           agg_en, agg_count, res_valid
  );

  modport slave (
    input  start, k_len, res_ready,
    output busy, err, pe_clear, rd_en, rd_addr, a_vld, b_vld,
           agg_en, agg_count, res_valid
  );

endinterface

// File: rtl/systolic_ctrl_skew_mask.sv
// rtl/systolic_ctrl_skew_mask.sv - skewed operand-valid window for the array edges
//
// Purpose: lane i carries operand k=t-i, valid while 0 <= t-i < K.
// Ports:
//   t    in  5  feed step index
//   k    in  5  inner dimension K
//   mask out N  per-lane valid window

module skew_mask
  import systolic_pkg::*;
(
  input  logic [4:0]   t,
  input  logic [4:0]   k,
  output logic [N-1:0] mask
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [5:0] LANE = 6'(i);
    // 6-bit compare so LANE+K cannot overflow.
    assign mask[i] = ({1'b0, t} >= LANE) && ({1'b0, t} < LANE + {1'b0, k});
  end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for the 4x4 systolic matrix-multiply tile
//
// Purpose: accepts a job (K), clears the PEs, drives the skewed operand
//          feed, steps the aggregator wavefront, then holds result-valid.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of systolic_if (handshake and array controls)

module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  systolic_if.slave  bus
);

  logic [2:0]   state, state_nxt;
  logic [4:0]   t, t_nxt;
  logic [4:0]   k;
  logic         err_q;
  logic [N-1:0] vld_q;
  logic [N-1:0] win_nxt;
  logic         k_ok;
  logic         accept;

  assign k_ok   = (bus.k_len != 5'd0) && (bus.k_len <= 5'(KMAX));
  assign accept = (state == S_IDLE) && bus.start && k_ok;

  always_comb begin
    state_nxt = state;
    t_nxt     = 5'd0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
      end
      S_FEED: begin
        if (t == feed_len(k) - 5'd1) state_nxt = S_COLLECT;
        else                         t_nxt     = t + 5'd1;
      end
      S_COLLECT: begin
        if (t == 5'(COLLECT_LEN - 1)) state_nxt = S_DONE;
        else                          t_nxt     = t + 5'd1;
      end
      S_DONE: begin
        if (bus.res_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The mask is evaluated on the next step index so the registered copy
  // lines up with t during FEED instead of trailing it by a cycle.
  skew_mask u_skew_mask (
    .t    (t_nxt),
    .k    (k),
    .mask (win_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      t     <= 5'd0;
      k     <= 5'd1;
      err_q <= 1'b0;
      vld_q <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      err_q <= (state == S_IDLE) && bus.start && !k_ok;
      vld_q <= (state_nxt == S_FEED) ? win_nxt : '0;
      if (accept) k <= bus.k_len;
    end
  end

  // Everything below decodes registered state only.
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;
  assign bus.pe_clear  = (state == S_CLEAR);
  assign bus.rd_en     = (state == S_FEED) && (t < k);
  assign bus.rd_addr   = bus.rd_en ? t : 5'd0;
  assign bus.a_vld     = vld_q;
  assign bus.b_vld     = vld_q;
  assign bus.agg_en    = (state == S_COLLECT);
  assign bus.agg_count = (state == S_COLLECT) ? t : 5'd0;
  assign bus.res_valid = (state == S_DONE);

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl

module tb_systolic_ctrl;
  import systolic_pkg::*;

  typedef struct packed {
    logic         busy;
    logic         err;
    logic         pe_clear;
    logic         rd_en;
    logic [4:0]   rd_addr;
    logic [N-1:0] a_vld;
    logic [N-1:0] b_vld;
    logic         agg_en;
    logic [4:0]   agg_count;
    logic         res_valid;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  bit   m_idle = 1'b1;
  int   done_cyc = 0;

  systolic_if bus ();

  systolic_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.busy      = bus.busy;
    o.err       = bus.err;
    o.pe_clear  = bus.pe_clear;
    o.rd_en     = bus.rd_en;
    o.rd_addr   = bus.rd_addr;
    o.a_vld     = bus.a_vld;
    o.b_vld     = bus.b_vld;
    o.agg_en    = bus.agg_en;
    o.agg_count = bus.agg_count;
    o.res_valid = bus.res_valid;
    return o;
  endfunction

  // Expected outputs d cycles after the accept edge of a job with inner dim kk.
  // Lane i is fed operand index (step - i) while that index lies in 0..kk-1.
  function automatic obs_t job_rec(int kk, int d);
    obs_t o;
    int   step;
    int   idx;
    o = '0;
    o.busy = 1'b1;
    if (d == 0) begin
      o.pe_clear = 1'b1;
    end else if (d <= kk + 2*N - 2) begin
      step = d - 1;
      if (step < kk) begin
        o.rd_en   = 1'b1;
        o.rd_addr = 5'(step);
      end
      for (int i = 0; i < N; i++) begin
        idx = step - i;
        if (idx >= 0 && idx < kk) o.a_vld[i] = 1'b1;
      end
      o.b_vld = o.a_vld;
    end else if (d <= kk + 4*N - 3) begin
      o.agg_en    = 1'b1;
      o.agg_count = 5'(d - (kk + 2*N - 1));
    end else begin
      o.res_valid = 1'b1;
    end
    return o;
  endfunction

  // Reference model: sees the same inputs at each rising edge, pushes the
  // output records it predicts for the cycles that follow.
  initial begin
    exp_t r;
    int   kk;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        m_idle = 1'b1;
      end else if (m_idle) begin
        if (bus.start) begin
          kk = int'(bus.k_len);
          if (kk >= 1 && kk <= KMAX) begin
            for (int d = 0; d <= kk + 4*N - 2; d++) begin
              r.cyc = cyc + d;
              r.o   = job_rec(kk, d);
              exp_q.push_back(r);
            end
            m_idle   = 1'b0;
            done_cyc = cyc + kk + 4*N - 2;
          end else begin
            r.cyc   = cyc;
            r.o     = '0;
            r.o.err = 1'b1;
            exp_q.push_back(r);
          end
        end
      end else if (cyc > done_cyc) begin
        if (bus.res_ready) begin
          m_idle = 1'b1;
        end else begin
          r.cyc         = cyc;
          r.o           = '0;
          r.o.busy      = 1'b1;
          r.o.res_valid = 1'b1;
          exp_q.push_back(r);
        end
      end
    end
  end

  // Monitor: compares whenever a record is due or the DUT shows activity.
  initial begin
    obs_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        act = sample();
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          total++;
          if (act !== e.o) begin
            bad++;
            $display("FAIL outputs cyc=%0d {busy,err,clr,rd_en,rd_addr,a_vld,b_vld,agg_en,agg_cnt,res_valid} got=%h want=%h",
                     cyc, act, e.o);
          end
        end else if (act != '0) begin
          total++;
          bad++;
          $display("FAIL unexpected_activity cyc=%0d got=%h want=0", cyc, act);
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [4:0] kl, input logic r);
    bus.start     = s;
    bus.k_len     = kl;
    bus.res_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string name);
    obs_t act;
    act = sample();
    total++;
    if (act !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, act);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) drive(1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: run did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int waited;
    bus.start     = 1'b0;
    bus.k_len     = 5'd0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_outputs");
    rst_n = 1'b1;
    drain(2);

    // Illegal lengths: err pulse only.
    drive(1'b1, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b1, 5'd17, 1'b1);
    drain(3);

    // K=4, K=1, K=16 with res_ready tied high.
    drive(1'b1, 5'd4, 1'b1);
    drain(25);
    drive(1'b1, 5'd1, 1'b1);
    drain(20);
    drive(1'b1, 5'd16, 1'b1);
    drain(35);

    // Hold DONE for 5 cycles with ignored start pulses.
    drive(1'b1, 5'd2, 1'b0);
    waited = 0;
    while (!bus.res_valid && waited < 40) begin
      drive(1'b0, 5'd2, 1'b0);
      waited++;
    end
    total++;
    if (!bus.res_valid) begin
      bad++;
      $display("FAIL done_wait got res_valid=0 want=1 within 40 cycles");
    end
    for (int i = 0; i < 5; i++) drive(1'(i % 2 == 0), 5'(i * 5), 1'b0);
    drive(1'b0, 5'd2, 1'b1);
    drain(3);

    // start held high across two K=3 jobs.
    repeat (25) drive(1'b1, 5'd3, 1'b1);
    drain(25);

    // Reset in the middle of FEED (K=4, t=3).
    drive(1'b1, 5'd4, 1'b1);
    repeat (4) drive(1'b0, 5'd4, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_feed");
    drive(1'b0, 5'd0, 1'b1);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_reset got=%b want=0", bus.busy);
    end
    drive(1'b1, 5'd2, 1'b1);
    drain(20);

    // Randomized traffic.
    repeat (1500) begin
      drive(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 20)),
            1'($urandom_range(0, 2) != 0));
    end
    drain(40);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
